psram_rd_capture: RTL and testbench

Read-data capture stage for the PSRAM controller. It sits directly downstream of `psram_core`: while the core holds the read-data phase, this block samples the PSRAM `DQS`/`IO` lines in the `clk_i` domain and detects both `DQS` edges (DDR). It shifts the received bytes MSB-first into a 64-bit bus word, or a single byte for config reads, and hands the result to the bus side with a one-cycle valid pulse. A timeout guards against a missing or stalled `DQS`.

---
 rtl/psram_rd_capture_pkg.sv | 27 ++
 rtl/psram_rd_capture_if.sv | 32 +++
 rtl/psram_rd_capture_dqs_sync.sv | 40 ++++
 rtl/psram_rd_capture.sv | 123 ++++++++++++
 tb/tb_psram_rd_capture.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/psram_rd_capture_pkg.sv
// Shared definitions for the PSRAM read-data capture stage.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: capture FSM state codes, byte-target constants, left-align helper.
package psram_rd_capture_pkg;

  typedef enum logic [1:0] {
    PSRAM_CAP_IDLE = 2'd0,
    PSRAM_CAP_WAIT = 2'd1,
    PSRAM_CAP_CAPT = 2'd2,
    PSRAM_CAP_DONE = 2'd3
  } cap_state_e;

  localparam logic [3:0] PSRAM_CAP_BUS_BYTES = 4'd8;
  localparam logic [3:0] PSRAM_CAP_CFG_BYTES = 4'd1;

  // Bytes are shifted in at the bottom, so a partial word of n bytes sits in
  // the low 8*n bits; move it up so byte 0 lands in [63:56] and the unfilled
  // low bytes read as zero. n = 0 shifts everything out.
  function automatic logic [63:0] left_align(input logic [63:0] v,
                                             input logic [3:0]  n);
    logic [6:0] sh;
    sh = {4'd8 - n, 3'b000};
    return v << sh;
  endfunction

endpackage

// File: rtl/psram_rd_capture_if.sv
// Capture-stage bundle between the PSRAM core / pads and the bus side.
// Latency: n/a (wires only).
// Backpressure: none; results are one-cycle pulses with held data.
// Ports: cap_start_i/cap_cflg_i/cfg_tmo_i arm a capture, psram_dqs_in_i and
//        psram_io_in_i are raw pad inputs, rd_data_o/cfg_data_o/rd_valid_o/
//        rd_err_o/busy_o report the result back.
interface psram_rd_capture_if #(
  parameter int TMO_WIDTH = 8
);
  logic                 cap_start_i;
  logic                 cap_cflg_i;
  logic [TMO_WIDTH-1:0] cfg_tmo_i;
  logic                 psram_dqs_in_i;
  logic [7:0]           psram_io_in_i;
  logic [63:0]          rd_data_o;
  logic [7:0]           cfg_data_o;
  logic                 rd_valid_o;
  logic                 rd_err_o;
  logic                 busy_o;

  // master: core + pads side that arms the capture and consumes the result
  modport master (
    output cap_start_i, cap_cflg_i, cfg_tmo_i, psram_dqs_in_i, psram_io_in_i,
    input  rd_data_o, cfg_data_o, rd_valid_o, rd_err_o, busy_o
  );

  // slave: the capture stage itself
  modport slave (
    input  cap_start_i, cap_cflg_i, cfg_tmo_i, psram_dqs_in_i, psram_io_in_i,
    output rd_data_o, cfg_data_o, rd_valid_o, rd_err_o, busy_o
  );
endinterface

// File: rtl/psram_rd_capture_dqs_sync.sv
// Synchronises raw DQS/IO pads into clk_i and flags DQS rising/falling edges.
// Latency: 2 cycles pad-to-io_o; edge flags valid alongside the same io_o.
// Backpressure: none; free-running pipeline.
// Ports: dqs_i/io_i raw pads in; io_o synced data; dqs_rise_o/dqs_fall_o flags.
module psram_rd_capture_dqs_sync (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       dqs_i,
  input  logic [7:0] io_i,
  output logic [7:0] io_o,
  output logic       dqs_rise_o,
  output logic       dqs_fall_o
);

  logic       dqs_s1, dqs_s2, dqs_s3;
  logic [7:0] io_s1, io_s2;

  // IO gets the same two stages as DQS, so io_s2 is the byte that travelled
  // with the strobe transition seen between dqs_s3 and dqs_s2.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dqs_s1 <= 1'b0;
      dqs_s2 <= 1'b0;
      dqs_s3 <= 1'b0;
      io_s1  <= 8'h00;
      io_s2  <= 8'h00;
    end else begin
      dqs_s1 <= dqs_i;
      dqs_s2 <= dqs_s1;
      dqs_s3 <= dqs_s2;
      io_s1  <= io_i;
      io_s2  <= io_s1;
    end
  end

  assign io_o       = io_s2;
  assign dqs_rise_o =  dqs_s2 & ~dqs_s3;
  assign dqs_fall_o = ~dqs_s2 &  dqs_s3;

endmodule

// File: rtl/psram_rd_capture.sv
// DDR read-data capture: assembles 8 bytes (bus) or 1 byte (config) off DQS.
// Latency: 3 cycles pad-to-capture; rd_valid_o one cycle after the last byte.
// Backpressure: none; result is a one-cycle pulse, data held until next start.
// Ports: clk_i/rst_n_i plain; cap (slave) carries start/config/timeout,
//        pad DQS/IO, and the rd_data_o/cfg_data_o/rd_valid_o/rd_err_o/busy_o
//        result.
module psram_rd_capture
  import psram_rd_capture_pkg::*;
#(
  parameter int TMO_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  psram_rd_capture_if.slave    cap
);

  logic       dqs_rise, dqs_fall, dqs_edge;
  logic [7:0] io_s2;

  psram_rd_capture_dqs_sync u_dqs_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .dqs_i      (cap.psram_dqs_in_i),
    .io_i       (cap.psram_io_in_i),
    .io_o       (io_s2),
    .dqs_rise_o (dqs_rise),
    .dqs_fall_o (dqs_fall)
  );

  assign dqs_edge = dqs_rise | dqs_fall;

  cap_state_e           state;
  logic [63:0]          sreg;
  logic [3:0]           cnt, tgt;
  logic [TMO_WIDTH-1:0] tmr, tmo_q;
  logic                 cflg_q;
  logic [63:0]          rd_data_q;
  logic [7:0]           cfg_data_q;
  logic                 rd_valid_q, rd_err_q, busy_q;

  logic [63:0] sreg_shift;
  logic [3:0]  cnt_inc;
  logic        cap_edge;

  // WAIT only accepts a rising edge: falling edges there are DQS preamble.
  always_comb begin
    sreg_shift = {sreg[55:0], io_s2};
    cnt_inc    = cnt + 4'd1;
    cap_edge   = 1'b0;
    if (state == PSRAM_CAP_WAIT)      cap_edge = dqs_rise;
    else if (state == PSRAM_CAP_CAPT) cap_edge = dqs_edge;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= PSRAM_CAP_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      tgt        <= '0;
      tmr        <= '0;
      tmo_q      <= '0;
      cflg_q     <= 1'b0;
      rd_data_q  <= '0;
      cfg_data_q <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        PSRAM_CAP_IDLE: begin
          if (cap.cap_start_i) begin
            sreg   <= '0;
            cnt    <= '0;
            tgt    <= cap.cap_cflg_i ? PSRAM_CAP_CFG_BYTES : PSRAM_CAP_BUS_BYTES;
            tmr    <= cap.cfg_tmo_i;
            tmo_q  <= cap.cfg_tmo_i;
            cflg_q <= cap.cap_cflg_i;
            busy_q <= 1'b1;
            state  <= PSRAM_CAP_WAIT;
          end
        end
        PSRAM_CAP_WAIT, PSRAM_CAP_CAPT: begin
          // An edge in the expiry cycle still counts: it is checked first.
          if (cap_edge) begin
            cnt <= cnt_inc;
            tmr <= tmo_q;
            if (cflg_q) cfg_data_q <= io_s2;
            else        sreg       <= sreg_shift;
            if (cnt_inc == tgt) begin
              state      <= PSRAM_CAP_DONE;
              rd_valid_q <= 1'b1;
              rd_err_q   <= 1'b0;
              if (!cflg_q) rd_data_q <= sreg_shift;
            end else begin
              state <= PSRAM_CAP_CAPT;
            end
          end else if (tmr == '0) begin
            state      <= PSRAM_CAP_DONE;
            rd_valid_q <= 1'b1;
            rd_err_q   <= 1'b1;
            if (cflg_q) cfg_data_q <= '0;
            else        rd_data_q  <= left_align(sreg, cnt);
          end else begin
            tmr <= tmr - TMO_WIDTH'(1);
          end
        end
        PSRAM_CAP_DONE: begin
          busy_q <= 1'b0;
          state  <= PSRAM_CAP_IDLE;
        end
        default: state <= PSRAM_CAP_IDLE;
      endcase
    end
  end

  assign cap.rd_data_o  = rd_data_q;
  assign cap.cfg_data_o = cfg_data_q;
  assign cap.rd_valid_o = rd_valid_q;
  assign cap.rd_err_o   = rd_err_q;
  assign cap.busy_o     = busy_q;

endmodule

// File: tb/tb_psram_rd_capture.sv
// Self-checking bench for psram_rd_capture: table of reads plus corner cases.
// Expected results are queued when a read is armed and checked on rd_valid_o.
module tb_psram_rd_capture;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miss;

  psram_rd_capture_if #(.TMO_WIDTH(8)) cap_if ();

  psram_rd_capture #(.TMO_WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cap     (cap_if)
  );

  typedef struct {
    logic        cflg;
    logic [7:0]  tmo;
    int          n_edges;
    logic [63:0] bytes;   // byte i sent on edge i, byte 0 in [63:56]
    logic [63:0] rd;
    logic [7:0]  cfg;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    logic [7:0]  cfg;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec = n_vec + 1;
    if (act !== exp_v) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_data"},  cap_if.rd_data_o, 64'h0);
    chk({tag, "_cfg_data"}, 64'(cap_if.cfg_data_o), 64'h0);
    chk({tag, "_rd_valid"}, 64'(cap_if.rd_valid_o), 64'h0);
    chk({tag, "_rd_err"},   64'(cap_if.rd_err_o), 64'h0);
    chk({tag, "_busy"},     64'(cap_if.busy_o), 64'h0);
  endtask

  // Scoreboard: every rd_valid_o pulse must match the oldest queued read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cap_if.rd_valid_o) begin
        if (exp_q.size() == 0) begin
          n_vec  = n_vec + 1;
          n_miss = n_miss + 1;
          $display("FAIL unexpected_valid: got rd_valid_o=1, want no pulse (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data",   cap_if.rd_data_o, e.rd);
          chk("cfg_data",  64'(cap_if.cfg_data_o), 64'(e.cfg));
          chk("rd_err",    64'(cap_if.rd_err_o), 64'(e.err));
          chk("valid_cyc", 64'(cyc), 64'(e.cyc));
          chk("busy_at_valid", 64'(cap_if.busy_o), 64'h1);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      n_vec  = n_vec + 1;
      n_miss = n_miss + 1;
      $display("FAIL drain_timeout: got %0d reads pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic arm(input logic cflg, input logic [7:0] tmo);
    cap_if.cap_start_i = 1'b1;
    cap_if.cap_cflg_i  = cflg;
    cap_if.cfg_tmo_i   = tmo;
    step();
    cap_if.cap_start_i = 1'b0;
  endtask

  // Arms one read, toggles DQS every 2 cycles, one byte per edge.
  // Expected rd_valid_o cycle derived from: edge i driven at s+1+2i,
  // 3 cycles pad-to-capture, timer counts tmo..0 before expiring.
  task automatic run_vec(input vec_t v, input bit mid_start);
    int   s;
    int   tgt;
    exp_t e;
    s     = cyc;
    tgt   = v.cflg ? 1 : 8;
    e.rd  = v.rd;
    e.cfg = v.cfg;
    e.err = v.err;
    if (v.n_edges >= tgt)     e.cyc = s + 2 * tgt + 2;
    else if (v.n_edges == 0)  e.cyc = s + int'(v.tmo) + 2;
    else                      e.cyc = s + 2 * v.n_edges + int'(v.tmo) + 3;
    exp_q.push_back(e);
    arm(v.cflg, v.tmo);
    for (int i = 0; i < v.n_edges; i++) begin
      cap_if.psram_io_in_i  = v.bytes[63 - 8 * i -: 8];
      cap_if.psram_dqs_in_i = ~cap_if.psram_dqs_in_i;
      if (mid_start && i == 3) begin
        cap_if.cap_start_i = 1'b1;
        cap_if.cap_cflg_i  = 1'b1;
        cap_if.cfg_tmo_i   = 8'd0;
      end
      step();
      cap_if.cap_start_i = 1'b0;
      step();
    end
    wait_drain();
    cap_if.psram_dqs_in_i = 1'b0;
    repeat (4) step();
    chk("busy_idle", 64'(cap_if.busy_o), 64'h0);
  endtask

  initial begin
    exp_t e;
    int   s;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    cap_if.cap_start_i    = 1'b0;
    cap_if.cap_cflg_i     = 1'b0;
    cap_if.cfg_tmo_i      = 8'd0;
    cap_if.psram_dqs_in_i = 1'b0;
    cap_if.psram_io_in_i  = 8'h00;

    vt[0] = '{1'b0, 8'd16, 8, 64'h1122334455667788, 64'h1122334455667788, 8'h00, 1'b0};
    vt[1] = '{1'b1, 8'd16, 4, 64'hA55AC33C00000000, 64'h1122334455667788, 8'hA5, 1'b0};
    vt[2] = '{1'b0, 8'd5,  0, 64'h0,                64'h0,                8'hA5, 1'b1};
    vt[3] = '{1'b0, 8'd4,  3, 64'hDEADBE0000000000, 64'hDEADBE0000000000, 8'hA5, 1'b1};
    vt[4] = '{1'b0, 8'd3,  8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'hA5, 1'b0};
    vt[5] = '{1'b1, 8'd2,  0, 64'h0,                64'h0123456789ABCDEF, 8'h00, 1'b1};

    repeat (3) step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) run_vec(vt[i], 1'b0);

    // Earliest restart: config timeout, then a new start in the cycle after
    // rd_valid_o, which must be accepted.
    s = cyc;
    e = '{64'h0123456789ABCDEF, 8'h00, 1'b1, s + 3};
    exp_q.push_back(e);
    arm(1'b1, 8'd1);
    for (int k = 0; k < 20 && !cap_if.rd_valid_o; k++) step();
    chk("restart_saw_valid", 64'(cap_if.rd_valid_o), 64'h1);
    step();
    chk("busy_after_valid", 64'(cap_if.busy_o), 64'h0);
    s = cyc;
    e = '{64'h0123456789ABCDEF, 8'h00, 1'b1, s + 2};
    exp_q.push_back(e);
    arm(1'b1, 8'd0);
    wait_drain();
    repeat (2) step();

    // Edge landing exactly on the expiry cycle with cfg_tmo_i = 0.
    cap_if.psram_dqs_in_i = 1'b1;
    cap_if.psram_io_in_i  = 8'h3C;
    step();
    s = cyc;
    e = '{64'h0123456789ABCDEF, 8'h3C, 1'b0, s + 2};
    exp_q.push_back(e);
    arm(1'b1, 8'd0);
    wait_drain();
    cap_if.psram_dqs_in_i = 1'b0;
    repeat (4) step();

    // Reset in the middle of a bus burst.
    arm(1'b0, 8'd16);
    for (int i = 0; i < 4; i++) begin
      cap_if.psram_io_in_i  = 8'h90 + 8'(i);
      cap_if.psram_dqs_in_i = ~cap_if.psram_dqs_in_i;
      repeat (2) step();
    end
    step();
    chk("busy_mid_burst", 64'(cap_if.busy_o), 64'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Full read after reset, with an extra start pulse mid-burst to ignore.
    run_vec('{1'b0, 8'd16, 8, 64'h8877665544332211, 64'h8877665544332211, 8'h00, 1'b0}, 1'b1);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
